// File: rtl/bk_subtractor_pipe.sv
// ----------------------------------------------------------------------------
// bk_subtractor_pipe
//   Two-stage pipelined, valid/ready handshaked subtractor computing
//   out_diff = in_a - in_b - borrow_in. Wide operands may be streamed
//   LS word first, one word per beat; the borrow between words is carried
//   internally. The arithmetic is done as a + ~b + cin with cin = ~borrow_in,
//   using a Brent-Kung prefix network: the up-sweep (borrow-independent group
//   terms) is computed before the stage-1 register, and the down-sweep plus
//   the final carry combine with cin is computed before the output register.
//
// Parameters
//   WIDTH       word width, power of two, 4..32
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand beat handshake
//   in_a, in_b            minuend / subtrahend word
//   in_first, in_last     beat is LS / MS word of an operation
//   out_valid/out_ready   result beat handshake
//   out_diff              difference word
//   out_borrow            borrow out of this word (unsigned a < b so far)
//   out_zero              all result words of this operation so far are zero
//   out_ovf               signed overflow at this word's MSB
//   out_last              copy of in_last for this beat
//
// Optional feature (macro BK_SUB_CMP_EN)
//   Adds out_lt_u, out_lt_s, out_eq comparison flags, valid on last beats
//   only and 0 on non-last beats. Without the macro these ports do not exist.
// ----------------------------------------------------------------------------
module bk_subtractor_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_last
`ifdef BK_SUB_CMP_EN
  ,
  output logic             out_lt_u,
  output logic             out_lt_s,
  output logic             out_eq
`endif
);

  localparam int LOG = $clog2(WIDTH);

  // Up-sweep of the Brent-Kung tree. Returns {G, P}; odd-rooted nodes hold
  // group terms, untouched positions keep the bitwise generate/propagate.
  function automatic logic [2*WIDTH-1:0] up_sweep(input logic [WIDTH-1:0] g_in,
                                                  input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    g = g_in;
    p = p_in;
    for (int l = 0; l < LOG; l++) begin
      for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
        g[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p[i] = p[i] & p[i - (1 << l)];
      end
    end
    return {g, p};
  endfunction

  // Down-sweep: fills in the remaining positions so every bit i holds the
  // prefix (G, P) over bits [0..i].
  function automatic logic [2*WIDTH-1:0] down_sweep(input logic [WIDTH-1:0] g_in,
                                                    input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    g = g_in;
    p = p_in;
    for (int l = LOG - 2; l >= 0; l--) begin
      for (int i = (3 << l) - 1; i < WIDTH; i += (2 << l)) begin
        g[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p[i] = p[i] & p[i - (1 << l)];
      end
    end
    return {g, p};
  endfunction

  // Handshake / pipeline state
  logic             ready_en;
  logic             s1_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic             move;

  // Stage-1 contents
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_gg;
  logic [WIDTH-1:0] s1_gp;
  logic             s1_first;
  logic             s1_last;

  // Chain state between words of one operation
  logic             chain_borrow;
  logic             chain_zero;
  logic             chain_open;

  // Stage-2 next values
  logic [2*WIDTH-1:0] up_terms;
  logic [2*WIDTH-1:0] pre_terms;
  logic [WIDTH-1:0]   pg;
  logic [WIDTH-1:0]   pp;
  logic [WIDTH:0]     carry;
  logic               eff_first;
  logic               cin;
  logic [WIDTH-1:0]   diff_new;
  logic               borrow_new;
  logic               zero_new;
  logic               ovf_new;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  // ready_en keeps in_ready low while reset is asserted.
  assign in_ready = ready_en && s1_adv;
  assign move     = s1_valid && s2_adv;

  assign up_terms = up_sweep(in_a & ~in_b, in_a | ~in_b);

  // Stage-2 arithmetic: down-sweep, carry combine with cin, result flags.
  always_comb begin
    pre_terms = down_sweep(s1_gg, s1_gp);
    pg        = pre_terms[2*WIDTH-1:WIDTH];
    pp        = pre_terms[WIDTH-1:0];
    // A beat without an open chain (after a last beat or reset) starts fresh.
    eff_first = s1_first || !chain_open;
    cin       = eff_first || !chain_borrow;
    carry     = {(WIDTH + 1){1'b0}};
    carry[0]  = cin;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i + 1] = pg[i] | (pp[i] & cin);
    end
    diff_new   = s1_a ^ ~s1_b ^ carry[WIDTH-1:0];
    borrow_new = !carry[WIDTH];
    zero_new   = (diff_new == {WIDTH{1'b0}}) && (eff_first || chain_zero);
    ovf_new    = (s1_a[WIDTH-1] ^ s1_b[WIDTH-1]) & (s1_a[WIDTH-1] ^ diff_new[WIDTH-1]);
  end

  // Input-ready enable: low during reset, high from the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Stage 1: capture operands, flags and borrow-independent up-sweep terms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= {WIDTH{1'b0}};
      s1_b     <= {WIDTH{1'b0}};
      s1_gg    <= {WIDTH{1'b0}};
      s1_gp    <= {WIDTH{1'b0}};
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid && ready_en;
      if (in_valid && ready_en) begin
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_gg    <= up_terms[2*WIDTH-1:WIDTH];
        s1_gp    <= up_terms[WIDTH-1:0];
        s1_first <= in_first;
        s1_last  <= in_last;
      end
    end
  end

  // Stage 2 (output register); holds all outputs while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_diff   <= {WIDTH{1'b0}};
      out_borrow <= 1'b0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
      out_last   <= 1'b0;
`ifdef BK_SUB_CMP_EN
      out_lt_u   <= 1'b0;
      out_lt_s   <= 1'b0;
      out_eq     <= 1'b0;
`endif
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_diff   <= diff_new;
        out_borrow <= borrow_new;
        out_zero   <= zero_new;
        out_ovf    <= ovf_new;
        out_last   <= s1_last;
`ifdef BK_SUB_CMP_EN
        out_lt_u   <= s1_last & borrow_new;
        out_lt_s   <= s1_last & (diff_new[WIDTH-1] ^ ovf_new);
        out_eq     <= s1_last & zero_new;
`endif
      end
    end
  end

  // Chain registers advance only when a beat moves into the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_borrow <= 1'b0;
      chain_zero   <= 1'b0;
      chain_open   <= 1'b0;
    end else if (move) begin
      if (s1_last) begin
        chain_borrow <= 1'b0;
        chain_zero   <= 1'b0;
        chain_open   <= 1'b0;
      end else begin
        chain_borrow <= borrow_new;
        chain_zero   <= zero_new;
        chain_open   <= 1'b1;
      end
    end
  end

endmodule
